mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and product width in bits; operands are signed fixed-point with 7 fractional bits.
REQ-002 SHALL have parameter MULT_LAT, default 0: register stages inside the shared multiplier (0 = combinational); legal range 0..4.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: grant enable; low blocks new grants only.
REQ-006 SHALL have port req_valid, input, 4: per-requester request valid.
REQ-007 SHALL have port req_a, input, 4*WIDTH: operand a per requester, requester i in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b, input, 4*WIDTH: operand b per requester, same packing as req_a.
REQ-009 SHALL have port req_ready, output, 4: one-hot or zero grant, combinational.
REQ-010 SHALL have port mult_a, output, WIDTH: registered operand a to the shared multiplier.
REQ-011 SHALL have port mult_b, output, WIDTH: registered operand b to the shared multiplier.
REQ-012 SHALL have port mult_p, input, WIDTH: product from the shared multiplier, valid MULT_LAT cycles after mult_a/mult_b change.
REQ-013 SHALL have port rsp_valid, output, 1: registered, one-cycle pulse per result.
REQ-014 SHALL have port rsp_id, output, 2: requester index of the current result.
REQ-015 SHALL have port rsp_p, output, WIDTH: registered product.
REQ-016 SHALL have port busy, output, 1: high while any accepted operation is still in flight.

Function
REQ-017 Grant: when en=1, SHALL assert req_ready for exactly one requester with req_valid=1, chosen by the arbitration order; when en=0 or req_valid=0, req_ready SHALL be 0.
REQ-018 Handshake: a request is accepted in a cycle where req_valid[i]=req_ready[i]=1; requesters hold operands until accepted; at most one acceptance per cycle.
REQ-019 Round-robin: the search SHALL start at pointer rr_ptr (2 bits) and ascend modulo 4; after each acceptance rr_ptr SHALL become winner+1 mod 4, so index 3 wraps to 0; with no acceptance rr_ptr is unchanged.
REQ-020 On acceptance, mult_a/mult_b SHALL load the winner's operands at the next edge; with no acceptance they hold their value.
REQ-021 SHALL carry a valid+id tag through a 1+MULT_LAT stage shift register aligned with the multiplier.
REQ-022 Latency: a request accepted in cycle n SHALL give rsp_valid=1 in cycle n+2+MULT_LAT, with rsp_id=winner and rsp_p=mult_p sampled at the tag's last stage.
REQ-023 Throughput: SHALL accept one operation per cycle back to back; results return in acceptance order; there is no response backpressure.
REQ-024 rsp_id and rsp_p SHALL hold their last value while rsp_valid=0.
REQ-025 busy SHALL be the OR of all tag-stage valid bits plus rsp_valid; dropping en SHALL NOT cancel in-flight operations.

Reset
REQ-026 When rst=1 at an edge, SHALL clear rr_ptr, mult_a, mult_b, all tag stages, rsp_valid, rsp_id, rsp_p and busy to 0.
REQ-027 During rst, req_ready SHALL be 0.
REQ-028 Reset mid-operation SHALL discard every in-flight result; no rsp_valid pulse follows for those results.

Configuration
REQ-029 Macro MULT_ARBITER_FIXED_PRIO_EN SHALL select the arbitration policy.
- Defined: fixed priority, requester 0 highest and 3 lowest; rr_ptr is not implemented.
- Undefined: round-robin per REQ-019.
- All other behaviour, including latency, is identical in both builds.

Verification
REQ-030 MULT_LAT=0, requester 1 sends a=544, b=420 (4.25 x 3.28) with a behavioural Q.7 multiplier model -> rsp_valid two cycles after acceptance, rsp_id=1, rsp_p=1785.
REQ-031 All four req_valid held high for 8 cycles, round-robin build -> grants in order 0,1,2,3,0,1,2,3; eight results in the same order, one per cycle.
REQ-032 Same stimulus, MULT_ARBITER_FIXED_PRIO_EN build -> requester 0 granted every cycle; requesters 1..3 starve.
REQ-033 MULT_LAT=3, three back-to-back acceptances -> rsp_valid high in cycles n+5, n+6, n+7; busy falls the cycle after the last pulse.
REQ-034 rst asserted one cycle after two acceptances -> no rsp_valid pulse afterwards; rr_ptr=0 and the next grant goes to the lowest valid index.
REQ-035 en=0 with req_valid=4'b1111 -> req_ready=0 throughout; in-flight results still complete; grants resume on the cycle en returns to 1.

Source files
------------

// File: rtl/mult_arbiter.sv
// Four-requester arbiter feeding one shared Q.7 multiplier; results return in acceptance order with a requester tag.
// Build option: define MULT_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 highest); default is round-robin.
module mult_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MULT_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    output logic [3:0]         req_ready,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic [WIDTH-1:0]   mult_p,
    output logic               rsp_valid,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_p,
    output logic               busy
);
    localparam int NUM_REQ = 4;
    localparam int STAGES  = 1 + MULT_LAT;

    logic [1:0] win_idx;
    logic       win_found;
    logic       accept;

`ifdef MULT_ARBITER_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (and final) writer.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_idx   = 2'(k);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;
    logic [1:0] cand;

    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found && req_valid[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // 2-bit add wraps 3 back to 0 for free.
    assign rr_ptr_d = accept ? (win_idx + 2'd1) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= 2'd0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign accept    = en && !rst && win_found;
    assign req_ready = accept ? (4'b0001 << win_idx) : 4'b0000;

    logic [WIDTH-1:0] mult_a_q;
    logic [WIDTH-1:0] mult_a_d;
    logic [WIDTH-1:0] mult_b_q;
    logic [WIDTH-1:0] mult_b_d;

    always_comb begin
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        if (accept) begin
            mult_a_d = req_a[win_idx*WIDTH +: WIDTH];
            mult_b_d = req_b[win_idx*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else begin
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
        end
    end

    assign mult_a = mult_a_q;
    assign mult_b = mult_b_q;

    // Tag stage 0 lines up with the operand register; the last stage with mult_p.
    logic [STAGES-1:0]      tag_vld_q;
    logic [STAGES-1:0][1:0] tag_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= accept;
            tag_id_q[0]  <= win_idx;
            for (int s = 1; s < STAGES; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    logic             rsp_valid_q;
    logic [1:0]       rsp_id_q;
    logic [WIDTH-1:0] rsp_p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_p_q     <= '0;
        end else begin
            rsp_valid_q <= tag_vld_q[STAGES-1];
            if (tag_vld_q[STAGES-1]) begin
                rsp_id_q <= tag_id_q[STAGES-1];
                rsp_p_q  <= mult_p;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = (|tag_vld_q) || rsp_valid_q;

endmodule
